// File: rtl/rob_commit.sv
// Reorder buffer commit stage: in-order allocation, out-of-order writeback, and up to CMT_W in-order commits per cycle.
// A mispredicted entry ends its commit group and triggers a one-cycle squash of everything younger.
`ifndef RENAME_WIDTH
`define RENAME_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif
`ifndef ROB_COMMIT_INFO_T
`define ROB_COMMIT_INFO_T
typedef struct packed {
    logic       has_rd;
    logic       ismv;
    logic [4:0] ilrd_idx;
    logic [5:0] iprd_idx;
    logic [5:0] prev_iprd_idx;
} renameCommitInfo_t;
`endif

module rob_commit #(
    parameter int DEPTH = 32,
    parameter int INS_W = `RENAME_WIDTH,
    parameter int CMT_W = `COMMIT_WIDTH,
    parameter int WB_W  = 4,
    localparam int IW = $clog2(DEPTH),
    localparam int PW = IW + 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_can_insert,
    input  logic [INS_W-1:0]  i_insert_vld,
    input  renameCommitInfo_t i_insert_info   [INS_W],
    output logic [PW-1:0]     o_insert_robIdx [INS_W],
    input  logic [WB_W-1:0]   i_wb_vld,
    input  logic [PW-1:0]     i_wb_robIdx     [WB_W],
    input  logic [WB_W-1:0]   i_wb_mispred,
    output logic [CMT_W-1:0]  o_commit_vld,
    output renameCommitInfo_t o_commitInfo    [CMT_W],
    output logic              o_squash_vld,
    output logic              o_empty
);
    typedef enum logic {RUN, SQUASH} state_t;

    localparam logic [PW:0] MAX_CNT = (PW+1)'(DEPTH - INS_W);

    state_t            r_state, w_state_nxt;
    logic [PW-1:0]     r_head, r_tail;
    logic [DEPTH-1:0]  r_occ, r_cmp, r_misp;
    logic [DEPTH-1:0]  r_wrap;
    renameCommitInfo_t r_info [DEPTH];

    logic [CMT_W-1:0]  r_commit_vld_p1;
    renameCommitInfo_t r_commit_info_p1 [CMT_W];
    logic              r_squash_p1;

    logic [PW-1:0]     w_count, w_ins_cnt, w_sel_cnt;
    logic [PW-1:0]     w_cidx [CMT_W];
    logic [CMT_W-1:0]  w_sel;
    logic              w_squash;
    logic [WB_W-1:0]   w_wb_ok;

    assign w_count      = r_tail - r_head;
    assign o_empty      = (r_head == r_tail);
    // A pending squash must also block inserts, since those slots are about to be discarded.
    assign o_can_insert = (r_state == RUN) && !w_squash && ({1'b0, w_count} <= MAX_CNT);

    for (genvar k = 0; k < INS_W; k++) begin : g_ins
        assign o_insert_robIdx[k] = r_tail + PW'(k);
    end

    for (genvar j = 0; j < CMT_W; j++) begin : g_cidx
        assign w_cidx[j] = r_head + PW'(j);
    end

    for (genvar p = 0; p < WB_W; p++) begin : g_wb
        assign w_wb_ok[p] = r_occ[i_wb_robIdx[p][IW-1:0]] &&
                            (r_wrap[i_wb_robIdx[p][IW-1:0]] == i_wb_robIdx[p][IW]);
    end

    always_comb begin
        w_ins_cnt = '0;
        for (int k = 0; k < INS_W; k++) begin
            w_ins_cnt = w_ins_cnt + PW'(i_insert_vld[k]);
        end
    end

    // Selection uses only registered complete bits, so a same-cycle writeback commits a cycle later.
    always_comb begin
        logic chain;
        w_sel     = '0;
        w_sel_cnt = '0;
        w_squash  = 1'b0;
        chain     = (r_state == RUN);
        for (int j = 0; j < CMT_W; j++) begin
            if (chain && r_occ[w_cidx[j][IW-1:0]] && r_cmp[w_cidx[j][IW-1:0]]) begin
                w_sel[j]  = 1'b1;
                w_sel_cnt = w_sel_cnt + PW'(1);
                if (r_misp[w_cidx[j][IW-1:0]]) begin
                    w_squash = 1'b1;
                    chain    = 1'b0;
                end
            end else begin
                chain = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_squash) w_state_nxt = SQUASH;
            SQUASH:  w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            r_cmp  <= '0;
            r_misp <= '0;
        end else begin
            r_head <= r_head + w_sel_cnt;
            if (w_squash) begin
                r_tail <= r_head + w_sel_cnt;
                r_occ  <= '0;
                r_cmp  <= '0;
                r_misp <= '0;
            end else begin
                for (int j = 0; j < CMT_W; j++) begin
                    if (w_sel[j]) r_occ[w_cidx[j][IW-1:0]] <= 1'b0;
                end
                for (int p = 0; p < WB_W; p++) begin
                    if (i_wb_vld[p] && w_wb_ok[p]) begin
                        r_cmp[i_wb_robIdx[p][IW-1:0]] <= 1'b1;
                        if (i_wb_mispred[p]) r_misp[i_wb_robIdx[p][IW-1:0]] <= 1'b1;
                    end
                end
                if (o_can_insert) begin
                    r_tail <= r_tail + w_ins_cnt;
                    for (int k = 0; k < INS_W; k++) begin
                        if (i_insert_vld[k]) begin
                            r_occ[o_insert_robIdx[k][IW-1:0]]  <= 1'b1;
                            r_cmp[o_insert_robIdx[k][IW-1:0]]  <= 1'b0;
                            r_misp[o_insert_robIdx[k][IW-1:0]] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (o_can_insert) begin
            for (int k = 0; k < INS_W; k++) begin
                if (i_insert_vld[k]) begin
                    r_info[o_insert_robIdx[k][IW-1:0]] <= i_insert_info[k];
                    r_wrap[o_insert_robIdx[k][IW-1:0]] <= o_insert_robIdx[k][IW];
                end
            end
        end
    end

    // Commit output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_commit_vld_p1 <= '0;
            r_squash_p1     <= 1'b0;
            for (int j = 0; j < CMT_W; j++) r_commit_info_p1[j] <= '0;
        end else begin
            r_commit_vld_p1 <= w_sel;
            r_squash_p1     <= w_squash;
            for (int j = 0; j < CMT_W; j++) begin
                r_commit_info_p1[j] <= w_sel[j] ? r_info[w_cidx[j][IW-1:0]] : '0;
            end
        end
    end

    assign o_commit_vld = r_commit_vld_p1;
    assign o_squash_vld = r_squash_p1;
    for (genvar j = 0; j < CMT_W; j++) begin : g_cout
        assign o_commitInfo[j] = r_commit_info_p1[j];
    end
endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: in-order commit, partial completion, full/wrap, squash and reset-in-squash.
`ifndef ROB_COMMIT_INFO_T
`define ROB_COMMIT_INFO_T
typedef struct packed {
    logic       has_rd;
    logic       ismv;
    logic [4:0] ilrd_idx;
    logic [5:0] iprd_idx;
    logic [5:0] prev_iprd_idx;
} renameCommitInfo_t;
`endif

module tb_rob_commit;
    logic              clk = 1'b0;
    logic              rst;
    logic              can_ins;
    logic [3:0]        ins_vld;
    renameCommitInfo_t ins_info [4];
    logic [5:0]        ins_idx  [4];
    logic [3:0]        wb_vld;
    logic [5:0]        wb_idx   [4];
    logic [3:0]        wb_misp;
    logic [3:0]        cvld;
    renameCommitInfo_t cinfo    [4];
    logic              sq;
    logic              empty;

    int checks = 0;
    int errors = 0;
    int t_tail = 0;
    int seq    = 1;
    renameCommitInfo_t exp_info [32];

    rob_commit dut (
        .clk(clk), .rst(rst), .o_can_insert(can_ins),
        .i_insert_vld(ins_vld), .i_insert_info(ins_info), .o_insert_robIdx(ins_idx),
        .i_wb_vld(wb_vld), .i_wb_robIdx(wb_idx), .i_wb_mispred(wb_misp),
        .o_commit_vld(cvld), .o_commitInfo(cinfo), .o_squash_vld(sq), .o_empty(empty)
    );

    always #5 clk = ~clk;

    function automatic renameCommitInfo_t mk(input int s);
        logic [31:0]       v;
        renameCommitInfo_t r;
        v               = s;
        r.has_rd        = v[0];
        r.ismv          = v[1];
        r.ilrd_idx      = v[4:0] ^ 5'h15;
        r.iprd_idx      = v[5:0] + 6'd3;
        r.prev_iprd_idx = v[5:0] ^ 6'h2A;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ins_go(input int n);
        for (int k = 0; k < 4; k++) begin
            ins_vld[k]  = (k < n);
            ins_info[k] = mk(seq + k);
            if (k < n) exp_info[(t_tail + k) % 32] = mk(seq + k);
        end
        t_tail = (t_tail + n) % 64;
        seq    = seq + n;
    endtask

    task automatic ins_clear();
        ins_vld = '0;
        for (int k = 0; k < 4; k++) ins_info[k] = '0;
    endtask

    task automatic wb(input int p, input int idx, input logic m);
        wb_vld[p]  = 1'b1;
        wb_idx[p]  = 6'(idx);
        wb_misp[p] = m;
    endtask

    task automatic wb_clear();
        wb_vld  = '0;
        wb_misp = '0;
        for (int p = 0; p < 4; p++) wb_idx[p] = '0;
    endtask

    initial begin
        rst = 1'b1;
        ins_clear();
        wb_clear();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_can_ins", 32'(can_ins), 1);
        chk("rst_cvld", 32'(cvld), 0);
        chk("rst_sq", 32'(sq), 0);
        chk("rst_idx0", 32'(ins_idx[0]), 0);

        // four inserts, all complete in one cycle
        ins_go(4);
        chk("ins_idx3", 32'(ins_idx[3]), 3);
        tick();
        ins_clear();
        for (int p = 0; p < 4; p++) wb(p, p, 1'b0);
        tick();
        wb_clear();
        chk("wb_cycle_cvld", 32'(cvld), 0);
        tick();
        chk("grp4_cvld", 32'(cvld), 4'b1111);
        chk("grp4_info2", 32'(cinfo[2]), 32'(exp_info[2]));
        chk("grp4_prev3", 32'(cinfo[3].prev_iprd_idx), 32'(exp_info[3].prev_iprd_idx));
        chk("grp4_empty", 32'(empty), 1);

        // holes in completion stop the group
        ins_go(4);
        tick();
        ins_clear();
        wb(0, 4, 1'b0);
        wb(1, 6, 1'b0);
        tick();
        wb_clear();
        tick();
        chk("hole_cvld", 32'(cvld), 4'b0001);
        chk("hole_info0", 32'(cinfo[0]), 32'(exp_info[4]));
        chk("hole_info1_zero", 32'(cinfo[1]), 0);
        tick();
        chk("hole_stall", 32'(cvld), 0);
        wb(0, 5, 1'b0);
        tick();
        wb_clear();
        tick();
        chk("fill_cvld", 32'(cvld), 4'b0011);
        chk("fill_info1", 32'(cinfo[1]), 32'(exp_info[6]));
        wb(0, 7, 1'b0);
        tick();
        wb_clear();
        tick();
        chk("last_cvld", 32'(cvld), 4'b0001);
        chk("last_empty", 32'(empty), 1);

        // stale writeback (wrap bit differs) is ignored
        ins_go(1);
        tick();
        ins_clear();
        wb(0, 40, 1'b0);
        tick();
        wb_clear();
        tick();
        chk("stale_cvld", 32'(cvld), 0);
        chk("stale_empty", 32'(empty), 0);
        wb(0, 8, 1'b0);
        tick();
        wb_clear();
        tick();
        chk("fresh_cvld", 32'(cvld), 4'b0001);
        chk("fresh_empty", 32'(empty), 1);

        // fill all 32 entries starting at robIdx 9
        for (int i = 0; i < 8; i++) begin
            ins_go(4);
            tick();
        end
        ins_clear();
        chk("full_can_ins", 32'(can_ins), 0);
        chk("full_idx0", 32'(ins_idx[0]), 41);
        ins_vld = 4'b1111;
        for (int k = 0; k < 4; k++) ins_info[k] = mk(99);
        tick();
        ins_clear();
        chk("full_ignored_idx0", 32'(ins_idx[0]), 41);
        for (int p = 0; p < 4; p++) wb(p, 9 + p, 1'b0);
        tick();
        chk("full_still", 32'(can_ins), 0);
        for (int p = 0; p < 4; p++) wb(p, 13 + p, 1'b0);
        tick();
        chk("free_cvld", 32'(cvld), 4'b1111);
        chk("free_can_ins", 32'(can_ins), 1);
        for (int b = 2; b < 6; b++) begin
            for (int p = 0; p < 4; p++) wb(p, (9 + 4 * b + p) % 64, 1'b0);
            tick();
        end
        wb_clear();
        tick();
        chk("wrap_cvld", 32'(cvld), 4'b1111);
        chk("wrap_info2_e31", 32'(cinfo[2]), 32'(exp_info[31]));
        chk("wrap_info3_e0", 32'(cinfo[3]), 32'(exp_info[0]));

        // mispredict on robIdx 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        t_tail = 0;
        ins_go(4);
        tick();
        ins_clear();
        for (int p = 0; p < 4; p++) wb(p, p, p == 1);
        tick();
        wb_clear();
        chk("decide_can_ins", 32'(can_ins), 0);
        ins_vld = 4'b1111;
        for (int k = 0; k < 4; k++) ins_info[k] = mk(77);
        tick();
        ins_clear();
        chk("sq_cvld", 32'(cvld), 4'b0011);
        chk("sq_pulse", 32'(sq), 1);
        chk("sq_empty", 32'(empty), 1);
        chk("sq_can_ins", 32'(can_ins), 0);
        chk("sq_info1", 32'(cinfo[1]), 32'(exp_info[1]));
        tick();
        chk("post_sq", 32'(sq), 0);
        chk("post_cvld", 32'(cvld), 0);
        chk("post_can_ins", 32'(can_ins), 1);
        chk("post_idx0", 32'(ins_idx[0]), 2);
        chk("post_empty", 32'(empty), 1);

        // reset lands while in SQUASH
        ins_go(4);
        tick();
        ins_clear();
        wb(0, 2, 1'b1);
        tick();
        wb_clear();
        tick();
        chk("sq2_pulse", 32'(sq), 1);
        chk("sq2_cvld", 32'(cvld), 4'b0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_sq_sq", 32'(sq), 0);
        chk("rst_sq_cvld", 32'(cvld), 0);
        chk("rst_sq_info0", 32'(cinfo[0]), 0);
        chk("rst_sq_empty", 32'(empty), 1);
        chk("rst_sq_can_ins", 32'(can_ins), 1);
        chk("rst_sq_idx0", 32'(ins_idx[0]), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rob_commit.md
ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 SHALL have parameters: DEPTH, default 32, number of entries (power of two); INS_W, default `RENAME_WIDTH, insert lanes; CMT_W, default `COMMIT_WIDTH, commit lanes; WB_W, default 4, writeback ports.
REQ-002 SHALL have ports, as name  direction  width  meaning:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- o_can_insert  out  1  at least INS_W entries free and state RUN.
- i_insert_vld  in  INS_W  per-lane insert; set bits contiguous from bit 0.
- i_insert_info  in  renameCommitInfo_t[INS_W]  per-lane has_rd, ismv, ilrd_idx, iprd_idx, prev_iprd_idx.
- o_insert_robIdx  out  (log2 DEPTH+1)[INS_W]  allocated index with wrap bit.
- i_wb_vld  in  WB_W  writeback valid.
- i_wb_robIdx  in  (log2 DEPTH+1)[WB_W]  completing entry.
- i_wb_mispred  in  WB_W  completing entry requires squash after it commits.
- o_commit_vld  out  CMT_W  registered per-lane commit valid, contiguous from bit 0.
- o_commitInfo  out  renameCommitInfo_t[CMT_W]  registered payload of committed entries.
- o_squash_vld  out  1  registered full-pipeline squash pulse.
- o_empty  out  1  no occupied entries.

Function
REQ-003 SHALL keep head and tail pointers of log2(DEPTH)+1 bits; empty when equal; full when index bits equal and wrap bits differ; count = tail - head modulo 2*DEPTH.
REQ-004 SHALL, on a clock edge with o_can_insert=1, write lane k of i_insert_vld to entry tail+k, clear its complete/mispred flags, and advance tail by popcount(i_insert_vld).
REQ-005 SHALL drive o_insert_robIdx[k] = tail+k combinationally every cycle.
REQ-006 SHALL ignore i_insert_vld when o_can_insert=0, including inserts in the cycle the squash decision is made.
REQ-007 SHALL, on i_wb_vld[p], set complete for entry i_wb_robIdx[p] and OR in i_wb_mispred[p], only if that entry is occupied and its stored wrap bit matches; otherwise ignore.
REQ-008 SHALL select commit lane j (0..CMT_W-1) when entry head+j is occupied and complete, lanes 0..j-1 selected, and none of them flagged mispred.
REQ-009 SHALL register the selection into o_commit_vld/o_commitInfo on the next edge (1-cycle latency from being committable to visible commit) and advance head by the selected count on that edge.
REQ-010 SHALL not commit in the same cycle an entry whose complete bit is being set by writeback; it becomes committable the following cycle.
REQ-011 SHALL have FSM states RUN and SQUASH; reset to RUN.
REQ-012 SHALL, in RUN, when a selected lane carries mispred: commit lanes up to and including it, set tail := new head, invalidate all entries, assert o_squash_vld on the next cycle alongside that commit, and enter SQUASH.
REQ-013 SHALL, in SQUASH, hold o_can_insert=0, select no commits, and return to RUN after exactly one cycle.
REQ-014 SHALL assert o_squash_vld for exactly one cycle per squash.
REQ-015 SHALL handle pointer wrap so entry DEPTH-1 followed by entry 0 commit in the same group.
REQ-016 SHALL allow insert, writeback and commit in the same cycle; free count for o_can_insert uses the registered head (commits free space the next cycle).
REQ-017 SHALL drive o_commitInfo to zero for lanes with o_commit_vld=0.

Reset
REQ-018 SHALL, when rst=1 at an edge, set head=tail=0, clear all occupied/complete/mispred flags, state RUN, o_commit_vld=0, o_commitInfo=0, o_squash_vld=0.
REQ-019 SHALL, after reset, show o_empty=1 and o_can_insert=1 on the first cycle.
REQ-020 SHALL abandon any in-progress squash or commit group when rst asserts mid-operation.

Verification
REQ-021 Insert 4 lanes at reset, wb robIdx 0..3 in one cycle -> next cycle no commit, following cycle o_commit_vld=4'b1111, prev_iprd_idx echoed, o_empty=1 after.
REQ-022 Insert 4, wb only robIdx 0,2 -> o_commit_vld=4'b0001; wb robIdx 1 later -> o_commit_vld=4'b0011 (entries 1,2).
REQ-023 Fill 32 entries -> o_can_insert=0, inserts ignored; commit 4 -> o_can_insert=1 following cycle; commit across index 31->0 in one group.
REQ-024 Insert 4, wb robIdx 0..3 with mispred on robIdx 1 -> o_commit_vld=4'b0011 and o_squash_vld=1 same cycle, then o_can_insert=0 one cycle, o_empty=1, next insert gets robIdx = head.
REQ-025 Writeback to stale robIdx (wrap bit mismatch) -> no state change; rst asserted during SQUASH -> all outputs zero, o_can_insert=1 next cycle.
